// File: rtl/div_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | piano_div_pkg : shared size defaults and FSM state type, div_sched |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package piano_div_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREQ  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/div_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_sched_if : request/operand/result bundle of the shared divider |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface div_sched_if
  import piano_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] dividend;
  logic [NREQ*WIDTH-1:0] divisor;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      quotient;
  logic [WIDTH-1:0]      remainder;
  logic                  div0;
  logic                  busy;

  modport master (
    output req, dividend, divisor,
    input  ack, quotient, remainder, div0, busy
  );

  modport slave (
    input  req, dividend, divisor,
    output ack, quotient, remainder, div0, busy
  );

endinterface
`default_nettype wire

// File: rtl/div_sched_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_core : restoring shift-subtract datapath with result registers |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module div_core
  import piano_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             fin_run_i,
  input  logic             fin_zero_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div0_o
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] quo_res_q;
  logic [WIDTH-1:0] rem_res_q;
  logic             div0_q;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] rem_d;

  // rem_q < divisor always holds, so the top bit of the W+1 bit difference is the borrow.
  assign trial = {rem_q, acc_q[WIDTH-1]} - {1'b0, dsr_q};
  assign fits  = ~trial[WIDTH];
  assign rem_d = fits ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], acc_q[WIDTH-1]};
  assign acc_d = {acc_q[WIDTH-2:0], fits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      quo_res_q <= '0;
      rem_res_q <= '0;
      div0_q    <= 1'b0;
    end else begin
      if (load_i) begin
        acc_q <= dividend_i;
        rem_q <= '0;
        dsr_q <= divisor_i;
      end else if (step_i) begin
        acc_q <= acc_d;
        rem_q <= rem_d;
      end

      if (fin_run_i) begin
        quo_res_q <= acc_d;
        rem_res_q <= rem_d;
        div0_q    <= 1'b0;
      end else if (fin_zero_i) begin
        // No steps ran, so acc_q still holds the untouched dividend.
        quo_res_q <= '1;
        rem_res_q <= acc_q;
        div0_q    <= 1'b1;
      end
    end
  end

  assign quotient_o  = quo_res_q;
  assign remainder_o = rem_res_q;
  assign div0_o      = div0_q;

endmodule
`default_nettype wire

// File: rtl/div_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_sched : round-robin scheduler sharing one divider among NREQ   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module div_sched
  import piano_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic       clk,
  input  logic       rst_n,
  div_sched_if.slave bus
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CW   = $clog2(WIDTH + 1);

  state_t            state_q;
  logic [IDXW-1:0]   grant_q;
  logic [IDXW-1:0]   rr_ptr_q;
  logic [IDXW-1:0]   rr_ptr_d;
  logic [CW-1:0]     step_q;
  logic [NREQ-1:0]   ack_q;
  logic              busy_q;

  logic [NREQ-1:0]   hi_mask;
  logic [NREQ-1:0]   req_hi;
  logic [NREQ-1:0]   pick;
  logic [IDXW-1:0]   grant_idx;
  logic              any_req;
  logic              last_step;
  logic [WIDTH-1:0]  cap_dividend;
  logic [WIDTH-1:0]  cap_divisor;
  logic              core_load;
  logic              core_step;
  logic              core_fin_run;
  logic              core_fin_zero;
  logic [WIDTH-1:0]  quotient;
  logic [WIDTH-1:0]  remainder;
  logic              div0;

  // Prefer requesters at or above rr_ptr; fall back to the lowest one when none is.
  always_comb begin
    hi_mask = '0;
    for (int k = 0; k < NREQ; k++) begin
      hi_mask[k] = (k >= int'(rr_ptr_q));
    end
    req_hi    = bus.req & hi_mask;
    pick      = (req_hi != '0) ? req_hi : bus.req;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (pick[k]) grant_idx = k[IDXW-1:0];
    end
  end

  assign any_req      = |bus.req;
  assign rr_ptr_d     = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDXW'(1);
  assign cap_dividend = bus.dividend[int'(grant_idx)*WIDTH +: WIDTH];
  assign cap_divisor  = bus.divisor[int'(grant_idx)*WIDTH +: WIDTH];
  assign last_step    = (step_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      step_q   <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      ack_q  <= '0;
      busy_q <= (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q  <= grant_idx;
            rr_ptr_q <= rr_ptr_d;
            step_q   <= '0;
            state_q  <= (cap_divisor == '0) ? ZERO : RUN;
          end
        end
        RUN: begin
          step_q <= step_q + CW'(1);
          if (last_step) state_q <= DONE;
        end
        ZERO: state_q <= DONE;
        DONE: begin
          ack_q   <= NREQ'(1) << grant_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_load     = (state_q == IDLE) && any_req;
  assign core_step     = (state_q == RUN);
  assign core_fin_run  = (state_q == RUN) && last_step;
  assign core_fin_zero = (state_q == ZERO);

  div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (core_load),
    .step_i     (core_step),
    .fin_run_i  (core_fin_run),
    .fin_zero_i (core_fin_zero),
    .dividend_i (cap_dividend),
    .divisor_i  (cap_divisor),
    .quotient_o (quotient),
    .remainder_o(remainder),
    .div0_o     (div0)
  );

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.quotient  = quotient;
  assign bus.remainder = remainder;
  assign bus.div0      = div0;

endmodule
`default_nettype wire
